// File: rtl/instr_trace_buffer_pkg.sv
// -----------------------------------------------------------------------------
// instr_trace_buffer_pkg
// Shared definitions for the instruction trace buffer:
//   - MIPS instruction field positions used by the record decoder
//   - trace capture state encoding
//   - width of one buffered trace record
// Configuration macro: TRACE_TIMESTAMP_EN widens each record by a 32-bit
// cycle stamp (96-bit records instead of 64-bit).
// -----------------------------------------------------------------------------
package instr_trace_buffer_pkg;

    // MSB position of each MIPS I-type field inside the instruction word
    localparam int OPC_MSB = 31;
    localparam int RS_MSB  = 25;
    localparam int RT_MSB  = 20;
    localparam int OFF_MSB = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

    // Record layout: {[stamp,] pc, instr}
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = 96;
`else
    localparam int REC_W = 64;
`endif

endpackage

// File: rtl/instr_trace_buffer_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Parameterised synchronous FIFO with wrap-bit pointers.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous empty (pointers back to zero)
//   push, wdata     write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop             read request; ignored while empty
//   full, empty     occupancy flags
//   rdata           head entry, read combinationally from the registered array
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // observable between valid pointers, and a reset would cost a flop-based
    // array instead of plain memory.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_trace_buffer.sv
// -----------------------------------------------------------------------------
// instr_trace_buffer
// Passive capture stage behind the single-cycle MIPS datapath. While a capture
// window is open, every committed PC/instruction is pushed into a FIFO and
// presented as a decoded trace record on a valid/ready stream.
// Configuration macro: TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter whose value is stored with each sample and shown on out_stamp.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, clear          open capture window / abort, flush and go idle
//   cap_en, cap_pc,
//   cap_instr             commit strobe and committed PC / instruction
//   out_valid, out_ready  record stream handshake
//   out_pc .. out_offset  head record and its decoded MIPS fields
//   out_stamp             head record cycle stamp (TRACE_TIMESTAMP_EN only)
//   busy, done            capturing / window finished and fully drained
//   overflow, drop_cnt    sticky drop flag and saturating drop count
// -----------------------------------------------------------------------------
module instr_trace_buffer
    import instr_trace_buffer_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int CAPTURE_LIMIT = 17,
    parameter int DROP_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              cap_en,
    input  logic [31:0]       cap_pc,
    input  logic [31:0]       cap_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [15:0]       out_offset,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]       out_stamp
`endif
);

    // Sample counter wide enough to hold CAPTURE_LIMIT; wraps when unlimited.
    localparam int CNT_W = (CAPTURE_LIMIT < 2) ? 1 : $clog2(CAPTURE_LIMIT + 1);

    trace_state_t     state;
    logic [CNT_W-1:0] sample_cnt;
    logic             sample;
    logic             push;
    logic             pop;
    logic             drop;
    logic             at_limit;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] wdata;
    logic [REC_W-1:0] head;

    // clear outranks sampling; start has no effect outside IDLE.
    assign sample   = (state == CAPTURE) && cap_en && !clear;
    assign pop      = out_valid && out_ready;
    assign push     = sample && (!fifo_full || pop);
    assign drop     = sample && fifo_full && !pop;
    assign at_limit = (CAPTURE_LIMIT != 0) &&
                      (sample_cnt == CNT_W'(CAPTURE_LIMIT - 1));

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      cycle_cnt <= '0;
        else if (clear) cycle_cnt <= '0;
        else            cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign wdata     = {cycle_cnt, cap_pc, cap_instr};
    assign out_stamp = head[95:64];
`else
    assign wdata = {cap_pc, cap_instr};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else if (clear) begin
            state      <= IDLE;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CAPTURE;
                        sample_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (sample) begin
                        // Every sample counts toward the limit, stored or not.
                        sample_cnt <= sample_cnt + 1'b1;
                        if (at_limit) state <= DONE;
                        if (drop) begin
                            overflow <= 1'b1;
                            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (head)
    );

    assign out_valid  = !fifo_empty;
    assign busy       = (state == CAPTURE);
    assign done       = (state == DONE) && fifo_empty;

    assign out_pc     = head[63:32];
    assign out_instr  = head[31:0];
    assign out_opcode = out_instr[OPC_MSB -: 6];
    assign out_rs     = out_instr[RS_MSB -: 5];
    assign out_rt     = out_instr[RT_MSB -: 5];
    assign out_offset = out_instr[OFF_MSB -: 16];

endmodule

// File: tb/tb_instr_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_trace_buffer
// Directed self-checking bench. Instance dut uses the default parameters
// (DEPTH 16, LIMIT 17); instance bdut uses LIMIT 20 for the backpressure and
// reset-during-capture scenarios. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_instr_trace_buffer;

    logic        clk;
    logic        reset;

    logic        start, clear, cap_en, out_ready;
    logic [31:0] cap_pc, cap_instr;
    logic        out_valid, busy, done, overflow;
    logic [31:0] out_pc, out_instr;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt;
    logic [15:0] out_offset;
    logic [7:0]  drop_cnt;

    logic        b_start, b_clear, b_cap_en, b_out_ready;
    logic [31:0] b_cap_pc, b_cap_instr;
    logic        b_out_valid, b_busy, b_done, b_overflow;
    logic [31:0] b_out_pc, b_out_instr;
    logic [5:0]  b_out_opcode;
    logic [4:0]  b_out_rs, b_out_rt;
    logic [15:0] b_out_offset;
    logic [7:0]  b_drop_cnt;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] out_stamp, b_out_stamp;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_trace_buffer #(.DEPTH(16), .CAPTURE_LIMIT(17), .DROP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .cap_en(cap_en), .cap_pc(cap_pc), .cap_instr(cap_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rt(out_rt), .out_offset(out_offset),
        .busy(busy), .done(done), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef TRACE_TIMESTAMP_EN
        , .out_stamp(out_stamp)
`endif
    );

    instr_trace_buffer #(.DEPTH(16), .CAPTURE_LIMIT(20), .DROP_W(8)) bdut (
        .clk(clk), .reset(reset), .start(b_start), .clear(b_clear),
        .cap_en(b_cap_en), .cap_pc(b_cap_pc), .cap_instr(b_cap_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr), .out_opcode(b_out_opcode),
        .out_rs(b_out_rs), .out_rt(b_out_rt), .out_offset(b_out_offset),
        .busy(b_busy), .done(b_done), .overflow(b_overflow), .drop_cnt(b_drop_cnt)
`ifdef TRACE_TIMESTAMP_EN
        , .out_stamp(b_out_stamp)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Distinct, easily decoded instruction word per sample index
    function automatic logic [31:0] mk_instr(input int i);
        return {6'(i + 1), 5'(i), 5'(31 - i), 16'(16'h1000 + i)};
    endfunction

    task automatic test_reset;
        if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", out_valid); n_fail++; end
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
        n_checks++;
        if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); n_fail++; end
        n_checks++;
        if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %b want 0", overflow); n_fail++; end
        n_checks++;
        if (drop_cnt !== 8'd0) begin $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); n_fail++; end
        n_checks++;
    endtask

    task automatic test_basic;
        logic [31:0] exp_i;
        out_ready = 1'b1;
        start = 1'b1; step; start = 1'b0;
        if (busy !== 1'b1) begin $display("FAIL basic_busy got %b want 1", busy); n_fail++; end
        n_checks++;
        for (int i = 0; i < 17; i++) begin
            exp_i = mk_instr(i);
            cap_en = 1'b1; cap_pc = 32'(4 * i); cap_instr = exp_i;
            step;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== exp_i) begin
                $display("FAIL basic_rec%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i), exp_i);
                n_fail++;
            end
            n_checks++;
            if (out_opcode !== 6'(i + 1) || out_rs !== 5'(i) || out_rt !== 5'(31 - i) ||
                out_offset !== 16'(16'h1000 + i)) begin
                $display("FAIL basic_fields%0d got op=%h rs=%0d rt=%0d off=%h", i,
                         out_opcode, out_rs, out_rt, out_offset);
                n_fail++;
            end
            n_checks++;
        end
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL basic_limit got busy=%b done=%b want busy=0 done=0", busy, done); n_fail++;
        end
        n_checks++;
        // 18th commit lands in DONE and must be ignored
        cap_pc = 32'hDEAD_BEEF; cap_instr = 32'hFFFF_FFFF;
        step; cap_en = 1'b0;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            $display("FAIL basic_done got valid=%b done=%b want valid=0 done=1", out_valid, done); n_fail++;
        end
        n_checks++;
        clear = 1'b1; step; clear = 1'b0;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_clear got done=%b busy=%b want 0 0", done, busy); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_full_pop;
        out_ready = 1'b0;
        start = 1'b1; step; start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cap_en = 1'b1; cap_pc = 32'(4 * i); cap_instr = mk_instr(i);
            step;
        end
        if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
            $display("FAIL fullpop_head got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); n_fail++;
        end
        n_checks++;
        // Full FIFO: sample and pop together
        cap_pc = 32'd64; cap_instr = mk_instr(16); out_ready = 1'b1;
        step; cap_en = 1'b0;
        if (out_pc !== 32'd4 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            $display("FAIL fullpop_same got pc=%h ovf=%b drops=%0d want pc=4 ovf=0 drops=0",
                     out_pc, overflow, drop_cnt);
            n_fail++;
        end
        n_checks++;
        for (int k = 0; k < 16; k++) begin
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k + 1))) begin
                $display("FAIL fullpop_drain%0d got v=%b pc=%h want v=1 pc=%h",
                         k, out_valid, out_pc, 32'(4 * (k + 1)));
                n_fail++;
            end
            n_checks++;
            step;
        end
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            $display("FAIL fullpop_empty got v=%b done=%b want v=0 done=1", out_valid, done); n_fail++;
        end
        n_checks++;
        clear = 1'b1; step; clear = 1'b0;
    endtask

    task automatic test_clear;
        out_ready = 1'b0;
        start = 1'b1; step; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cap_en = 1'b1; cap_pc = 32'(32'h200 + 4 * i); cap_instr = mk_instr(i);
            step;
        end
        clear = 1'b1; start = 1'b1; cap_en = 1'b1;
        step;
        clear = 1'b0; start = 1'b0; cap_en = 1'b0;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 8'd0) begin
            $display("FAIL clear_idle got v=%b busy=%b done=%b drops=%0d want 0 0 0 0",
                     out_valid, busy, done, drop_cnt);
            n_fail++;
        end
        n_checks++;
        // Fresh window of 17
        out_ready = 1'b1;
        start = 1'b1; step; start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cap_en = 1'b1; cap_pc = 32'(32'h400 + 4 * i); cap_instr = mk_instr(i);
            step;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h400 + 4 * i)) begin
                $display("FAIL clear_fresh%0d got v=%b pc=%h want v=1 pc=%h",
                         i, out_valid, out_pc, 32'(32'h400 + 4 * i));
                n_fail++;
            end
            n_checks++;
        end
        cap_en = 1'b0;
        step;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL clear_fresh_done got done=%b v=%b want 1 0", done, out_valid); n_fail++;
        end
        n_checks++;
        clear = 1'b1; step; clear = 1'b0;
    endtask

    task automatic test_decode;
        out_ready = 1'b0;
        clear = 1'b1; step; clear = 1'b0;
        start = 1'b1; step; start = 1'b0;
        cap_en = 1'b1; cap_pc = 32'h0000_0100; cap_instr = 32'h8C22_FFFC;
        step; cap_en = 1'b0;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_opcode !== 6'b100011 ||
            out_rs !== 5'd1 || out_rt !== 5'd2 || out_offset !== 16'hFFFC) begin
            $display("FAIL decode_lw got v=%b pc=%h op=%b rs=%0d rt=%0d off=%h want v=1 pc=100 op=100011 rs=1 rt=2 off=fffc",
                     out_valid, out_pc, out_opcode, out_rs, out_rt, out_offset);
            n_fail++;
        end
        n_checks++;
        // Held record must stay stable under backpressure
        step;
        if (out_instr !== 32'h8C22_FFFC) begin
            $display("FAIL decode_hold got instr=%h want 8c22fffc", out_instr); n_fail++;
        end
        n_checks++;
`ifdef TRACE_TIMESTAMP_EN
        // Counter zeroed at the clear edge, 1 after the start edge: stamp = 1
        if (out_stamp !== 32'd1) begin
            $display("FAIL decode_stamp got %0d want 1", out_stamp); n_fail++;
        end
        n_checks++;
`endif
        clear = 1'b1; step; clear = 1'b0;
    endtask

    task automatic test_backpressure;
        b_out_ready = 1'b0;
        b_start = 1'b1; step; b_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_cap_en = 1'b1; b_cap_pc = 32'(4 * i); b_cap_instr = mk_instr(i);
            step;
        end
        b_cap_en = 1'b0;
        if (b_overflow !== 1'b1 || b_drop_cnt !== 8'd4 || b_busy !== 1'b0 || b_out_valid !== 1'b1) begin
            $display("FAIL bp_status got ovf=%b drops=%0d busy=%b v=%b want 1 4 0 1",
                     b_overflow, b_drop_cnt, b_busy, b_out_valid);
            n_fail++;
        end
        n_checks++;
        b_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (b_out_valid !== 1'b1 || b_out_pc !== 32'(4 * k)) begin
                $display("FAIL bp_drain%0d got v=%b pc=%h want v=1 pc=%h",
                         k, b_out_valid, b_out_pc, 32'(4 * k));
                n_fail++;
            end
            n_checks++;
            step;
        end
        if (b_out_valid !== 1'b0 || b_done !== 1'b1) begin
            $display("FAIL bp_empty got v=%b done=%b want 0 1", b_out_valid, b_done); n_fail++;
        end
        n_checks++;
        b_clear = 1'b1; step; b_clear = 1'b0;
    endtask

    task automatic test_async_reset;
        b_out_ready = 1'b0;
        b_start = 1'b1; step; b_start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            b_cap_en = 1'b1; b_cap_pc = 32'(4 * i); b_cap_instr = mk_instr(i);
            step;
        end
        b_cap_en = 1'b0;
        if (b_busy !== 1'b1 || b_overflow !== 1'b1 || b_out_valid !== 1'b1) begin
            $display("FAIL areset_pre got busy=%b ovf=%b v=%b want 1 1 1", b_busy, b_overflow, b_out_valid);
            n_fail++;
        end
        n_checks++;
        // Assert reset midway between edges and look before the next edge
        #3 reset = 1'b1;
        #1;
        if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_overflow !== 1'b0 || b_drop_cnt !== 8'd0) begin
            $display("FAIL areset_now got v=%b busy=%b ovf=%b drops=%0d want 0 0 0 0",
                     b_out_valid, b_busy, b_overflow, b_drop_cnt);
            n_fail++;
        end
        n_checks++;
        #2 reset = 1'b0;
        step;
        if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin
            $display("FAIL areset_after got busy=%b v=%b want 0 0", b_busy, b_out_valid); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; clear = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
        cap_pc = '0; cap_instr = '0;
        b_start = 1'b0; b_clear = 1'b0; b_cap_en = 1'b0; b_out_ready = 1'b0;
        b_cap_pc = '0; b_cap_instr = '0;
        #12 reset = 1'b0;
        step;

        test_reset;
        test_basic;
        test_full_pop;
        test_clear;
        test_decode;
        test_backpressure;
        test_async_reset;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_trace_buffer.md
Name: instr_trace_buffer

Overview:
- Passive capture stage downstream of the single-cycle MIPS datapath. Samples the committed PC and instruction each cycle and buffers them in a FIFO.
- Presents decoded trace records (PC, instruction, opcode, rs, rt, offset) on a valid/ready stream for a monitor or file-writer.
- Replaces the per-cycle hierarchical probing used for trace output. A sample limit bounds the trace window.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- CAPTURE_LIMIT, 17, samples taken before stopping; 0 = unlimited
- DROP_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin capture window
- clear  in  1  pulse: abort, flush, return to idle
- cap_en  in  1  datapath commit strobe; current PC/instr valid this cycle
- cap_pc  in  32  committed PC
- cap_instr  in  32  committed instruction word
- out_valid  out  1  trace record available
- out_ready  in  1  consumer accepts record
- out_pc  out  32  record PC
- out_instr  out  32  record instruction
- out_opcode  out  6  out_instr[31:26]
- out_rs  out  5  out_instr[25:21]
- out_rt  out  5  out_instr[20:16]
- out_offset  out  16  out_instr[15:0], raw
- busy  out  1  state == CAPTURE
- done  out  1  state == DONE and FIFO empty
- overflow  out  1  sticky: a sample was dropped
- drop_cnt  out  DROP_W  saturating count of dropped samples

Behaviour:
- Reset: state IDLE, pointers 0, sample count 0, overflow 0, drop_cnt 0. Outputs: out_valid 0, busy 0, done 0. Data outputs are don't-care while out_valid = 0. Storage array is not reset.
- States:
  - IDLE: start → CAPTURE.
  - CAPTURE: after CAPTURE_LIMIT samples (LIMIT ≠ 0) → DONE.
  - DONE: holds until clear.
  - clear, from any state → IDLE.
- Priority: clear > start > sample. If clear and start occur in the same cycle, the block goes to IDLE.
- Sample: cap_en = 1 while in CAPTURE. Each sample increments the sample count, whether it is written or dropped.
  - The transition to DONE happens on the same edge as the LIMIT-th sample.
  - cap_en is ignored in IDLE and DONE.
- Write: on a sample, {cap_pc, cap_instr} is written at the write pointer if not full, or if full and a pop happens in the same cycle.
- Drop: a sample is dropped when the FIFO is full with no pop. A drop sets overflow and increments drop_cnt, which saturates at all-ones.
- Pop: out_valid & out_ready. Advances the read pointer.
- Pointers: log2(DEPTH)+1 bits with wrap bit. Empty = pointers equal. Full = MSBs differ and the remaining bits are equal. Pointers wrap naturally.
- Latency: a sample accepted at edge N gives out_valid = 1 after edge N, with no combinational path from cap_* to out_*.
- Output fields are taken combinationally from the registered head entry. They hold stable while out_valid = 1 and out_ready = 0.
- Simultaneous push and pop on an empty FIFO is impossible, because out_valid = 0.
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged.
- clear flushes the FIFO and zeroes the sample count, overflow and drop_cnt. A record being presented is discarded.
- Reset asserted mid-capture: all state is lost immediately. There is no drain.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter is added. It is zeroed by reset and by clear, and wraps.
  - Its value is stored with each accepted sample.
  - New output out_stamp, 32 bits, carries the stamp of the head record.
  - FIFO width becomes 96 bits.
- Undefined: no counter, no out_stamp port, 64-bit entries.

Decomposition:
- Shared package holds:
  - MIPS field positions: OPC_MSB = 31, RS_MSB = 25, RT_MSB = 20, OFF_MSB = 15.
  - Trace-state encoding: IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2.
  - The trace record width constant.
- One sub-module: trace_fifo. It is a parameterised width/depth synchronous FIFO exposing push, pop, full, empty and head data. The FSM, counters and field decode stay in the top block.

Test Plan:
- Basic run: start, then 17 cycles of cap_en with PC 0,4,…,64 and out_ready = 1. Required: 17 records in order, PC 0..64, correct opcode/rs/rt/offset. done = 1 after the last pop. cap_en on cycle 18 is ignored.
- Backpressure: DEPTH = 16, LIMIT = 20, out_ready = 0, 20 samples. Required: 16 entries, overflow = 1, drop_cnt = 4. Then out_ready = 1 drains PC 0..60 in order.
- Full plus simultaneous pop: with the FIFO full, sample and pop in the same cycle. Required: sample accepted, occupancy stays 16, overflow stays 0.
- Clear mid-capture: after 5 samples, pulse clear together with start. Required: state IDLE, out_valid = 0 next cycle, drop_cnt = 0. A following start captures a fresh 17.
- Async reset: assert reset between clock edges during CAPTURE. Required: out_valid, busy and overflow go to 0 immediately, before the next clk edge.
- Decode check: cap_instr = 0x8C22FFFC (lw). Required: out_opcode = 6'b100011, out_rs = 1, out_rt = 2, out_offset = 16'hFFFC. With TRACE_TIMESTAMP_EN, out_stamp equals the cycle count at capture.
